// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for a stepper driver.
// Each period lasts P cycles: step high for floor(P/2) cycles, then low for
// the remainder. P and dir are latched only at period boundaries.
// Optional feature: define STEP_PULSE_GEN_COUNT_EN to add a signed position
// counter output (step_count).
module step_pulse_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        dir_in,
  input  logic [31:0] T_value,
  output logic        step,
  output logic        dir,
  output logic        busy,
  output logic        period_done
`ifdef STEP_PULSE_GEN_COUNT_EN
  ,
  output logic signed [31:0] step_count
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, HIGH = 2'd1, LOW = 2'd2} state_t;

  state_t      r_state, w_state_nx;
  logic [31:0] r_cnt, w_cnt_nx;
  logic [31:0] r_per, w_per_nx;
  logic        r_dir, w_dir_nx;
  logic        r_step, r_busy, r_done;
  logic        w_latch;
  logic [31:0] w_clamp;
  logic [31:0] w_cnt_inc;
  logic [31:0] w_half;
  logic [31:0] w_last_nx;

  assign w_clamp   = (T_value < 32'd2) ? 32'd2 : T_value;
  assign w_cnt_inc = r_cnt + 32'd1;
  assign w_half    = r_per >> 1;
  assign w_last_nx = w_per_nx - 32'd1;

  // Next-state logic: latch a new period from IDLE or back-to-back at period end
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_per_nx   = r_per;
    w_dir_nx   = r_dir;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable) w_latch = 1'b1;
      end
      default: begin
        if (r_cnt == r_per - 32'd1) begin
          if (enable) begin
            w_latch = 1'b1;
          end else begin
            w_state_nx = IDLE;
            w_cnt_nx   = 32'd0;
          end
        end else begin
          w_cnt_nx   = w_cnt_inc;
          w_state_nx = (w_cnt_inc < w_half) ? HIGH : LOW;
        end
      end
    endcase
    if (w_latch) begin
      w_state_nx = HIGH;
      w_cnt_nx   = 32'd0;
      w_per_nx   = w_clamp;
      w_dir_nx   = dir_in;
    end
  end

  // State, counter, latched period and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= 32'd0;
      r_per   <= 32'd2;
      r_dir   <= 1'b0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_per   <= w_per_nx;
      r_dir   <= w_dir_nx;
      r_step  <= (w_state_nx == HIGH);
      r_busy  <= (w_state_nx != IDLE);
      r_done  <= (w_state_nx != IDLE) && (w_cnt_nx == w_last_nx);
    end
  end

  assign step        = r_step;
  assign dir         = r_dir;
  assign busy        = r_busy;
  assign period_done = r_done;

`ifdef STEP_PULSE_GEN_COUNT_EN
  logic signed [31:0] r_step_count;

  // Position counter moves on every latch, i.e. the edge where step rises
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_step_count <= 32'sd0;
    end else if (w_latch) begin
      r_step_count <= w_dir_nx ? (r_step_count + 32'sd1) : (r_step_count - 32'sd1);
    end
  end

  assign step_count = r_step_count;
`endif

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen: directed scenarios plus random
// enable/dir/T traffic compared each cycle against a period-schedule model.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        dir_in;
  logic [31:0] T_value;
  logic        step, dir, busy, period_done;
`ifdef STEP_PULSE_GEN_COUNT_EN
  logic signed [31:0] step_count;
`endif

  step_pulse_gen dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .dir_in     (dir_in),
    .T_value    (T_value),
    .step       (step),
    .dir        (dir),
    .busy       (busy),
    .period_done(period_done)
`ifdef STEP_PULSE_GEN_COUNT_EN
    ,
    .step_count (step_count)
`endif
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: a period is "running" with index k in [0, P); step high while k < P/2.
  bit          m_run;
  logic [31:0] m_k, m_P;
  bit          m_dir;
  logic [31:0] m_pos;

  // Observed phase lengths of the last completed period
  int hi_len, lo_len, last_hi, last_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_k = 0; m_P = 2; m_dir = 0; m_pos = 0;
    hi_len = 0; lo_len = 0;
  endtask

  task automatic model_start();
    m_P   = (T_value < 2) ? 32'd2 : T_value;
    m_dir = dir_in;
    m_k   = 0;
    m_run = 1;
    m_pos = m_pos + (dir_in ? 32'd1 : 32'hFFFF_FFFF);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (!m_run) begin
      if (enable) model_start();
    end else begin
      m_k = m_k + 1;
      if (m_k == m_P) begin
        if (enable) model_start();
        else m_run = 0;
      end
    end
    #1;
    chk("step", {31'd0, step}, {31'd0, m_run && (m_k < (m_P / 2))});
    chk("dir", {31'd0, dir}, {31'd0, m_dir});
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("period_done", {31'd0, period_done}, {31'd0, m_run && (m_k == m_P - 1)});
`ifdef STEP_PULSE_GEN_COUNT_EN
    chk("step_count", step_count, m_pos);
`endif
    if (busy) begin
      if (step) hi_len++;
      else lo_len++;
      if (period_done) begin
        last_hi = hi_len; last_lo = lo_len; hi_len = 0; lo_len = 0;
      end
    end
  endtask

  initial begin
    rst = 1; enable = 0; dir_in = 0; T_value = 0;
    model_reset();
    last_hi = 0; last_lo = 0;
    #5;
    chk("rst_step", {31'd0, step}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_done", {31'd0, period_done}, 32'd0);
    tick(); tick();
    rst = 0;
    // no start without enable
    repeat (3) tick();
    chk("idle_no_en", {31'd0, busy}, 32'd0);

    // T=0 clamps to 2: one step backward from reset
    enable = 1; dir_in = 0; T_value = 0;
    tick();
    enable = 0;
    tick();
    chk("p2_hi", last_hi, 32'd1);
    chk("p2_lo", last_lo, 32'd1);
    tick();
`ifdef STEP_PULSE_GEN_COUNT_EN
    chk("cnt_minus1", step_count, 32'hFFFF_FFFF);
`endif

    // T=1 clamps to 2; 5 steps forward then 3 back, back-to-back
    rst = 1; tick(); rst = 0;
    enable = 1; T_value = 1;
    for (int i = 0; i < 8; i++) begin
      dir_in = (i < 5);
      tick();
      if (i == 7) enable = 0;
      tick();
      chk("p2b_hi", last_hi, 32'd1);
    end
    tick();
`ifdef STEP_PULSE_GEN_COUNT_EN
    chk("cnt_plus2", step_count, 32'd2);
`endif

    // Odd period 7813: 3906 high / 3907 low; mid-period T change ignored
    enable = 1; T_value = 7813; dir_in = 1;
    tick();
    enable = 0; T_value = 5;
    repeat (7812) tick();
    chk("p7813_hi", last_hi, 32'd3906);
    chk("p7813_lo", last_lo, 32'd3907);
    tick();
    chk("p7813_idle", {31'd0, busy}, 32'd0);

    // T changes 2500 -> 1250 at cnt=1000: current period keeps 2500
    enable = 1; T_value = 2500;
    tick();
    repeat (1000) tick();
    T_value = 1250;
    repeat (1499) tick();
    chk("tchg_done", {31'd0, period_done}, 32'd1);
    chk("tchg_hi1", last_hi, 32'd1250);
    chk("tchg_lo1", last_lo, 32'd1250);
    tick();
    enable = 0;
    repeat (1249) tick();
    chk("tchg_hi2", last_hi, 32'd625);
    chk("tchg_lo2", last_lo, 32'd625);
    tick();

    // enable drops during HIGH with T=20833: period completes in full
    enable = 1; T_value = 20833;
    tick();
    repeat (100) tick();
    enable = 0;
    repeat (20732) tick();
    chk("edrop_hi", last_hi, 32'd10416);
    chk("edrop_lo", last_lo, 32'd10417);
    tick();
    chk("edrop_busy", {31'd0, busy}, 32'd0);
    chk("edrop_step", {31'd0, step}, 32'd0);

    // dir_in toggles mid-period: dir follows only at next latch
    enable = 1; T_value = 10; dir_in = 1;
    tick();
    repeat (3) tick();
    dir_in = 0;
    repeat (3) tick();
    chk("dir_hold", {31'd0, dir}, 32'd1);
    repeat (3) tick();
    tick();
    chk("dir_new", {31'd0, dir}, 32'd0);
    chk("dir_step", {31'd0, step}, 32'd1);

    // rst mid-HIGH: outputs drop before the next clock edge
    tick();
    #3 rst = 1;
    #1;
    chk("arst_step", {31'd0, step}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, period_done}, 32'd0);
    model_reset();
    enable = 0;
    tick();
    rst = 0;
    repeat (3) tick();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      enable  = ($urandom_range(0, 9) < 7);
      dir_in  = $urandom_range(0, 1);
      T_value = $urandom_range(0, 20);
      repeat ($urandom_range(1, 15)) tick();
    end
    enable = 0;
    repeat (40) tick();
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
